gpr_exec_unit: RTL and testbench

GPR_EXEC_UNIT -- requirements
Module: gpr_exec_unit

---
 rtl/gpr_exec_unit.sv | 186 ++++++++++++++++++
 tb/tb_gpr_exec_unit.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpr_exec_unit.sv
// rtl/gpr_exec_unit.sv - GPR execution unit (MOV/ALU ops, optional shift-add MUL enabled by macro GPR_EXEC_MUL_EN)
module gpr_exec_unit #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              sys_rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       ir,
   output logic              done,
   output logic              illegal,
   output logic [3:0]        flags,
   output logic [DATA_W-1:0] mul_hi,
   input  logic [REG_AW-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   localparam int NUM_REGS = 2 ** REG_AW;

   localparam logic [4:0] OP_MOVSGPR = 5'd0;
   localparam logic [4:0] OP_MOV     = 5'd1;
   localparam logic [4:0] OP_ADD     = 5'd2;
   localparam logic [4:0] OP_SUB     = 5'd3;
   localparam logic [4:0] OP_MUL     = 5'd4;
   localparam logic [4:0] OP_AND     = 5'd5;
   localparam logic [4:0] OP_OR      = 5'd6;
   localparam logic [4:0] OP_XOR     = 5'd7;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL} state_t;

   state_t              state;
   logic [4:0]          op_q;
   logic [REG_AW-1:0]   rdst_q;
   logic [DATA_W-1:0]   op_a;
   logic [DATA_W-1:0]   op_b;
   logic [DATA_W-1:0]   gpr [NUM_REGS];

   logic [REG_AW-1:0]   in_rs1;
   logic [REG_AW-1:0]   in_rs2;
   logic [DATA_W-1:0]   in_b;

   logic [DATA_W:0]     add_full;
   logic [DATA_W:0]     sub_full;
   logic                add_ovf;
   logic                sub_ovf;

   logic [DATA_W-1:0]   res;
   logic                wr_en;
   logic                ill_op;
   logic [3:0]          next_flags;

   assign in_ready = (state == S_IDLE);
   assign dbg_data = gpr[dbg_addr];

   assign in_rs1 = ir[17 +: REG_AW];
   assign in_rs2 = ir[11 +: REG_AW];
   assign in_b   = ir[16] ? DATA_W'(ir[15:0]) : gpr[in_rs2];

   assign add_full = {1'b0, op_a} + {1'b0, op_b};
   assign sub_full = {1'b0, op_a} - {1'b0, op_b};
   assign add_ovf  = (op_a[DATA_W-1] == op_b[DATA_W-1]) && (add_full[DATA_W-1] != op_a[DATA_W-1]);
   assign sub_ovf  = (op_a[DATA_W-1] != op_b[DATA_W-1]) && (sub_full[DATA_W-1] != op_a[DATA_W-1]);

`ifdef GPR_EXEC_MUL_EN
   localparam int CNT_W = $clog2(DATA_W);

   logic [DATA_W-1:0]   mul_hi_q;
   logic [DATA_W-1:0]   mul_acc;
   logic [CNT_W-1:0]    mul_cnt;
   logic [DATA_W:0]     mul_sum;

   // op_b doubles as the multiplier/low-product shift register; mul_acc holds the running high half
   assign mul_sum = {1'b0, mul_acc} + (op_b[0] ? {1'b0, op_a} : {(DATA_W+1){1'b0}});
   assign mul_hi  = mul_hi_q;
`else
   assign mul_hi  = '0;
`endif

   // Result, write enable and flag update for the instruction retiring in EXEC
   always_comb begin
      res        = '0;
      wr_en      = 1'b0;
      ill_op     = 1'b0;
      next_flags = flags;
      case (op_q)
         OP_MOVSGPR: begin res = mul_hi; wr_en = 1'b1; end
         OP_MOV:     begin res = op_b;   wr_en = 1'b1; end
         OP_ADD: begin
            res        = add_full[DATA_W-1:0];
            wr_en      = 1'b1;
            next_flags = {add_ovf, add_full[DATA_W], res[DATA_W-1], ~|res};
         end
         OP_SUB: begin
            res        = sub_full[DATA_W-1:0];
            wr_en      = 1'b1;
            next_flags = {sub_ovf, sub_full[DATA_W], res[DATA_W-1], ~|res};
         end
`ifdef GPR_EXEC_MUL_EN
         OP_MUL: begin
            res        = op_b;
            wr_en      = 1'b1;
            next_flags = {2'b00, res[DATA_W-1], ~|res};
         end
`endif
         OP_AND: begin
            res        = op_a & op_b;
            wr_en      = 1'b1;
            next_flags = {2'b00, res[DATA_W-1], ~|res};
         end
         OP_OR: begin
            res        = op_a | op_b;
            wr_en      = 1'b1;
            next_flags = {2'b00, res[DATA_W-1], ~|res};
         end
         OP_XOR: begin
            res        = op_a ^ op_b;
            wr_en      = 1'b1;
            next_flags = {2'b00, res[DATA_W-1], ~|res};
         end
         default: ill_op = 1'b1;
      endcase
   end

   // Control FSM: accept in IDLE, iterate in MUL, retire in EXEC; reset aborts without writes
   always_ff @(posedge clk) begin
      if (!sys_rst_n) begin
         state   <= S_IDLE;
         done    <= 1'b0;
         illegal <= 1'b0;
         flags   <= '0;
         op_q    <= '0;
         rdst_q  <= '0;
         op_a    <= '0;
         op_b    <= '0;
         for (int i = 0; i < NUM_REGS; i++) gpr[i] <= '0;
`ifdef GPR_EXEC_MUL_EN
         mul_hi_q <= '0;
         mul_acc  <= '0;
         mul_cnt  <= '0;
`endif
      end else begin
         done    <= 1'b0;
         illegal <= 1'b0;
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  op_q   <= ir[31:27];
                  rdst_q <= ir[22 +: REG_AW];
                  op_a   <= gpr[in_rs1];
                  op_b   <= in_b;
`ifdef GPR_EXEC_MUL_EN
                  mul_acc <= '0;
                  mul_cnt <= '0;
                  state   <= (ir[31:27] == OP_MUL) ? S_MUL : S_EXEC;
`else
                  state   <= S_EXEC;
`endif
               end
            end
            S_MUL: begin
`ifdef GPR_EXEC_MUL_EN
               mul_acc <= mul_sum[DATA_W:1];
               op_b    <= {mul_sum[0], op_b[DATA_W-1:1]};
               mul_cnt <= mul_cnt + 1'b1;
               if (mul_cnt == CNT_W'(DATA_W - 1)) state <= S_EXEC;
`else
               state <= S_IDLE;
`endif
            end
            S_EXEC: begin
               if (wr_en) gpr[rdst_q] <= res;
               flags   <= next_flags;
               done    <= 1'b1;
               illegal <= ill_op;
`ifdef GPR_EXEC_MUL_EN
               if (op_q == OP_MUL) mul_hi_q <= mul_acc;
`endif
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gpr_exec_unit.sv
// tb/tb_gpr_exec_unit.sv - scoreboard bench for gpr_exec_unit with random stimulus and reference model
module tb_gpr_exec_unit;

   localparam int DW = 32;
   localparam int AW = 5;
`ifdef GPR_EXEC_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif
   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -64'sd2147483648;

   logic          clk = 1'b0;
   logic          sys_rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [31:0]   ir;
   logic          done;
   logic          illegal;
   logic [3:0]    flags;
   logic [DW-1:0] mul_hi;
   logic [AW-1:0] dbg_addr;
   logic [DW-1:0] dbg_data;

   logic          mon_sel = 1'b0;
   logic [AW-1:0] mon_addr = '0;
   logic [AW-1:0] main_addr = '0;
   assign dbg_addr = mon_sel ? mon_addr : main_addr;

   always #5 clk = ~clk;

   gpr_exec_unit #(.DATA_W(DW), .REG_AW(AW)) dut (
      .clk(clk), .sys_rst_n(sys_rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .ir(ir), .done(done), .illegal(illegal), .flags(flags), .mul_hi(mul_hi),
      .dbg_addr(dbg_addr), .dbg_data(dbg_data)
   );

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] val;
      logic [3:0]  flg;
      logic        ill;
      logic [31:0] hi;
      int          lat;
      longint      due;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] m_gpr [32];
   logic [3:0]  m_flags;
   logic [31:0] m_hi;
   int          n_pass = 0;
   int          n_total = 0;
   longint      cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 32; i++) m_gpr[i] = '0;
      m_flags = '0;
      m_hi    = '0;
   endfunction

   function automatic exp_t model(input logic [31:0] insn);
      exp_t        e;
      logic [4:0]  op, rd;
      logic [31:0] a, b, r;
      logic [63:0] w;
      longint      sa, sbv, ss;
      op  = insn[31:27];
      rd  = insn[26:22];
      a   = m_gpr[insn[21:17]];
      b   = insn[16] ? {16'h0, insn[15:0]} : m_gpr[insn[15:11]];
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      e.ill = 1'b0;
      e.lat = 1;
      case (op)
         5'd0: m_gpr[rd] = m_hi;
         5'd1: m_gpr[rd] = b;
         5'd2: begin
            w = {32'h0, a} + {32'h0, b};
            r = w[31:0];
            ss = sa + sbv;
            m_gpr[rd] = r;
            m_flags = {(ss > SMAX) || (ss < SMIN), w[32], r[31], r == 32'h0};
         end
         5'd3: begin
            r = a - b;
            ss = sa - sbv;
            m_gpr[rd] = r;
            m_flags = {(ss > SMAX) || (ss < SMIN), a < b, r[31], r == 32'h0};
         end
         5'd4: begin
            if (MUL_EN) begin
               w = {32'h0, a} * {32'h0, b};
               m_gpr[rd] = w[31:0];
               m_hi = w[63:32];
               m_flags = {2'b00, w[31], w[31:0] == 32'h0};
               e.lat = DW + 1;
            end else begin
               e.ill = 1'b1;
            end
         end
         5'd5, 5'd6, 5'd7: begin
            r = (op == 5'd5) ? (a & b) : (op == 5'd6) ? (a | b) : (a ^ b);
            m_gpr[rd] = r;
            m_flags = {2'b00, r[31], r == 32'h0};
         end
         default: e.ill = 1'b1;
      endcase
      e.rd  = rd;
      e.val = m_gpr[rd];
      e.flg = m_flags;
      e.hi  = m_hi;
      e.due = 0;
      return e;
   endfunction

   function automatic logic [31:0] mki(input int op, input int rd, input int rs1, input logic [15:0] isrc);
      return {5'(op), 5'(rd), 5'(rs1), 1'b1, isrc};
   endfunction

   function automatic logic [31:0] mkr(input int op, input int rd, input int rs1, input int rs2);
      return {5'(op), 5'(rd), 5'(rs1), 1'b0, 5'(rs2), 11'h0};
   endfunction

   task automatic issue_start(input logic [31:0] insn, input bit hold);
      exp_t e;
      @(negedge clk);
      for (int i = 0; i < 200 && !in_ready; i++) @(negedge clk);
      if (!in_ready) begin
         n_total++;
         $display("FAIL ready_timeout: got in_ready=0 expected in_ready=1 within 200 cycles");
      end
      in_valid = 1'b1;
      ir = insn;
      e = model(insn);
      e.due = cyc + 1 + e.lat;
      sb.push_back(e);
      @(negedge clk);
      if (hold) begin
         ir = $urandom;
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 100; i++) begin
         if (sb.size() == 0) break;
         @(negedge clk);
      end
      if (sb.size() != 0) begin
         n_total++;
         $display("FAIL done_timeout: got %0d outstanding expected 0 after 100 cycles", sb.size());
         sb.delete();
      end
   endtask

   task automatic issue(input logic [31:0] insn);
      issue_start(insn, 1'b0);
      wait_idle();
   endtask

   task automatic read_reg(input int addr, output logic [31:0] v);
      main_addr = 5'(addr);
      #2;
      v = dbg_data;
   endtask

   task automatic sweep(input string tag);
      logic [31:0] v;
      for (int i = 0; i < 32; i++) begin
         read_reg(i, v);
         chk($sformatf("%s_gpr%0d", tag, i), 64'(v), 64'(m_gpr[i]));
      end
   endtask

   task automatic do_reset();
      sys_rst_n = 1'b0;
      @(negedge clk);
      sys_rst_n = 1'b1;
      sb.delete();
      model_reset();
   endtask

   // Monitor: pop the oldest expectation whenever the unit retires an instruction
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (done === 1'b1) begin
            if (sb.size() == 0) begin
               n_total++;
               $display("FAIL unexpected_done: got done=1 expected done=0 (nothing outstanding)");
            end else begin
               e = sb.pop_front();
               mon_addr = e.rd;
               mon_sel = 1'b1;
               #1;
               chk("illegal", 64'(illegal), 64'(e.ill));
               chk("flags", 64'(flags), 64'(e.flg));
               chk("mul_hi", 64'(mul_hi), 64'(e.hi));
               chk("gpr_rdst", 64'(dbg_data), 64'(e.val));
               chk("latency", 64'(cyc), 64'(e.due));
               mon_sel = 1'b0;
            end
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got no finish expected finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] v;
      logic [4:0]  op;
      logic [15:0] isrc;
      sys_rst_n = 1'b0;
      in_valid  = 1'b0;
      ir        = '0;
      model_reset();
      repeat (3) @(negedge clk);
      sys_rst_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_illegal", 64'(illegal), 64'd0);
      chk("rst_flags", 64'(flags), 64'd0);
      chk("rst_mul_hi", 64'(mul_hi), 64'd0);
      sweep("rst");

      for (int i = 0; i < 32; i++) issue(mki(1, i, 0, 16'd2));
      issue(mki(2, 0, 2, 16'd4));
      read_reg(0, v);
      chk("add_imm_result", 64'(v), 64'd6);
      chk("add_imm_flags", 64'(flags), 64'd0);

      issue(mki(1, 4, 0, 16'd2));
      issue(mki(1, 5, 0, 16'd2));
      issue(mkr(2, 0, 4, 5));
      read_reg(0, v);
      chk("add_reg_result", 64'(v), 64'd4);
      issue(mki(1, 4, 0, 16'd55));
      read_reg(4, v);
      chk("mov_imm_result", 64'(v), 64'd55);
      chk("mov_flags_kept", 64'(flags), 64'd0);

      issue(mki(1, 8, 0, 16'd0));
      issue(mki(1, 9, 0, 16'd1));
      issue(mkr(3, 1, 8, 9));
      read_reg(1, v);
      chk("sub_wrap_result", 64'(v), 64'hFFFF_FFFF);
      chk("sub_borrow_flags", 64'(flags), 64'b0110);
      issue(mki(2, 2, 1, 16'd1));
      read_reg(2, v);
      chk("add_carry_result", 64'(v), 64'd0);
      chk("add_carry_flags", 64'(flags), 64'b0101);
      issue(mkr(3, 3, 1, 1));
      chk("sub_self_flags", 64'(flags), 64'b0001);

      issue(mki(1, 1, 0, 16'h8000));
      issue(mkr(2, 1, 1, 1));
      issue(mki(1, 10, 0, 16'h8000));
      issue(mkr(2, 10, 10, 10));
      issue(mki(1, 3, 0, 16'h1234));
      issue_start(mkr(4, 3, 1, 10), 1'b1);
      wait_idle();
      read_reg(3, v);
      chk("mul_rdst", 64'(v), 64'(m_gpr[3]));
      chk("mul_hi_reg", 64'(mul_hi), 64'(m_hi));
      issue(mki(0, 6, 0, 16'h0));
      read_reg(6, v);
      chk("movsgpr_result", 64'(v), 64'(m_gpr[6]));

      issue(mki(20, 7, 1, 16'h00FF));
      sweep("illegal");

      for (int n = 0; n < 150; n++) begin
         op = ($urandom_range(0, 8) == 8) ? 5'($urandom_range(8, 31)) : 5'($urandom_range(0, 7));
         case ($urandom_range(0, 3))
            0: isrc = 16'hFFFF;
            1: isrc = 16'h8000;
            2: isrc = 16'h0000;
            default: isrc = 16'($urandom);
         endcase
         if ($urandom_range(0, 1) == 1)
            issue_start(mki(op, $urandom_range(0, 31), $urandom_range(0, 31), isrc), 1'($urandom_range(0, 1)));
         else
            issue_start(mkr(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31)), 1'($urandom_range(0, 1)));
         wait_idle();
      end
      sweep("random");

      issue_start(mkr(2, 11, 1, 1), 1'b0);
      do_reset();
      chk("abort_exec_ready", 64'(in_ready), 64'd1);
      chk("abort_exec_flags", 64'(flags), 64'd0);
      sweep("abort_exec");

      issue(mki(1, 12, 0, 16'hFFFF));
      issue(mkr(2, 12, 12, 12));
      issue_start(mkr(4, 13, 12, 12), 1'b0);
      repeat (8) @(negedge clk);
      do_reset();
      chk("abort_mul_ready", 64'(in_ready), 64'd1);
      chk("abort_mul_hi", 64'(mul_hi), 64'd0);
      repeat (40) @(negedge clk);
      sweep("abort_mul");

      wait_idle();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
